// File: rtl/spi_cmd_receiver_if.sv
// ---------------------------------------------------------------------------
// spi_cmd_receiver_if
//   Bus bundle between the SPI pins and the register-write side of the PWM
//   controller.
//   master : drives spi_cs_n / spi_sck / spi_mosi, observes the command outputs
//   slave  : the receiver; samples the SPI pins, drives the command outputs
//     spi_cs_n    chip select, active low, asynchronous
//     spi_sck     SPI clock, mode 0 (idles low), asynchronous
//     spi_mosi    serial data, MSB first, sampled on sck rise
//     cmd_word    last accepted frame
//     cmd_valid   1-cycle pulse per accepted frame
//     pwm_wr      one-hot 1-cycle PWM channel write strobe
//     clk_div_wr  1-cycle clock divider write strobe
//     frame_err   1-cycle pulse per rejected frame
//     err_count   saturating count of rejected frames
// ---------------------------------------------------------------------------
interface spi_cmd_receiver_if #(
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned NUM_PWM    = 8
);
  logic                  spi_cs_n;
  logic                  spi_sck;
  logic                  spi_mosi;
  logic [FRAME_BITS-1:0] cmd_word;
  logic                  cmd_valid;
  logic [NUM_PWM-1:0]    pwm_wr;
  logic                  clk_div_wr;
  logic                  frame_err;
  logic [7:0]            err_count;

  modport master (
    output spi_cs_n, spi_sck, spi_mosi,
    input  cmd_word, cmd_valid, pwm_wr, clk_div_wr, frame_err, err_count
  );

  modport slave (
    input  spi_cs_n, spi_sck, spi_mosi,
    output cmd_word, cmd_valid, pwm_wr, clk_div_wr, frame_err, err_count
  );
endinterface

// File: rtl/spi_cmd_receiver.sv
// ---------------------------------------------------------------------------
// spi_cmd_receiver
//   Mode-0 SPI slave front end for the PWM controller. Frames are
//   resynchronised into the clk domain, length-checked, and the top address
//   field is decoded into one-cycle write strobes.
//   clk    : system clock, at least 4x the sck frequency
//   rst_n  : synchronous, active-low reset
//   bus    : spi_cmd_receiver_if.slave (SPI pins in, command strobes out)
// ---------------------------------------------------------------------------
module spi_cmd_receiver #(
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned ADDR_BITS   = 4,
  parameter int unsigned NUM_PWM     = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  spi_cmd_receiver_if.slave        bus
);

  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT,
    FULL,
    OVERRUN
  } state_t;

  state_t                  r_state;
  logic [SYNC_STAGES-1:0]  r_cs_sync;
  logic [SYNC_STAGES-1:0]  r_sck_sync;
  logic [SYNC_STAGES-1:0]  r_mosi_sync;
  logic                    r_cs_hist;
  logic                    r_sck_hist;
  logic [FRAME_BITS-1:0]   r_shreg;
  logic [CNT_W-1:0]        r_cnt;
  logic [FRAME_BITS-1:0]   r_cmd_word;
  logic                    r_cmd_valid;
  logic [NUM_PWM-1:0]      r_pwm_wr;
  logic                    r_clk_div_wr;
  logic                    r_frame_err;
  logic [7:0]              r_err_count;

  logic                    w_cs;
  logic                    w_mosi;
  logic                    w_sck_rise;
  logic                    w_cs_rise;
  logic                    w_cs_fall;
  logic [FRAME_BITS-1:0]   w_shreg_nx;
  logic [CNT_W-1:0]        w_cnt_nx;
  state_t                  w_state_sck;
  logic [ADDR_BITS-1:0]    w_addr;

  assign w_cs       = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = r_sck_sync[SYNC_STAGES-1] & ~r_sck_hist;
  assign w_cs_rise  = w_cs & ~r_cs_hist;
  assign w_cs_fall  = ~w_cs & r_cs_hist;

  // sck edge is applied first; the cs_n decision below then sees the
  // updated shift register, bit count and state.
  always_comb begin
    w_shreg_nx  = r_shreg;
    w_cnt_nx    = r_cnt;
    w_state_sck = r_state;
    if (w_sck_rise) begin
      case (r_state)
        SHIFT: begin
          w_shreg_nx = {r_shreg[FRAME_BITS-2:0], w_mosi};
          w_cnt_nx   = r_cnt + 1'b1;
          if (r_cnt == CNT_W'(FRAME_BITS - 1)) w_state_sck = FULL;
        end
        FULL:    w_state_sck = OVERRUN;
        default: ;
      endcase
    end
  end

  assign w_addr = w_shreg_nx[FRAME_BITS-1 -: ADDR_BITS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // cs_n is held "selected" through reset so that a frame still in
      // progress at release is waited out in WAIT_IDLE, never picked up.
      r_cs_sync    <= '0;
      r_cs_hist    <= 1'b0;
      r_sck_sync   <= '0;
      r_sck_hist   <= 1'b0;
      r_mosi_sync  <= '0;
      r_state      <= WAIT_IDLE;
      r_shreg      <= '0;
      r_cnt        <= '0;
      r_cmd_word   <= '0;
      r_cmd_valid  <= 1'b0;
      r_pwm_wr     <= '0;
      r_clk_div_wr <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_cs_sync    <= {r_cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
      r_sck_sync   <= {r_sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
      r_mosi_sync  <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      r_cs_hist    <= w_cs;
      r_sck_hist   <= r_sck_sync[SYNC_STAGES-1];

      r_cmd_valid  <= 1'b0;
      r_pwm_wr     <= '0;
      r_clk_div_wr <= 1'b0;
      r_frame_err  <= 1'b0;

      r_shreg      <= w_shreg_nx;
      r_cnt        <= w_cnt_nx;
      r_state      <= w_state_sck;

      case (w_state_sck)
        WAIT_IDLE: if (w_cs) r_state <= IDLE;
        IDLE: begin
          if (w_cs_fall) begin
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT, OVERRUN: begin
          if (w_cs_rise) begin
            r_frame_err <= 1'b1;
            if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
            r_state <= IDLE;
          end
        end
        FULL: begin
          if (w_cs_rise) begin
            r_cmd_word  <= w_shreg_nx;
            r_cmd_valid <= 1'b1;
            if (32'(w_addr) < NUM_PWM)  r_pwm_wr     <= NUM_PWM'(1) << w_addr;
            if (32'(w_addr) == NUM_PWM) r_clk_div_wr <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= WAIT_IDLE;
      endcase
    end
  end

  assign bus.cmd_word   = r_cmd_word;
  assign bus.cmd_valid  = r_cmd_valid;
  assign bus.pwm_wr     = r_pwm_wr;
  assign bus.clk_div_wr = r_clk_div_wr;
  assign bus.frame_err  = r_frame_err;
  assign bus.err_count  = r_err_count;

endmodule

// File: tb/tb_spi_cmd_receiver.sv
// ---------------------------------------------------------------------------
// tb_spi_cmd_receiver
//   Directed and randomized frames against a frame-level reference model:
//   exactly 16 sck edges is accepted, anything else rejected, a reset
//   mid-frame discards the frame.
// ---------------------------------------------------------------------------
module tb_spi_cmd_receiver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_cmd_receiver_if #(.FRAME_BITS(16), .NUM_PWM(8)) bus ();

  spi_cmd_receiver #(
    .FRAME_BITS (16),
    .ADDR_BITS  (4),
    .NUM_PWM    (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // per-frame observations
  int         n_valid, n_err, n_div, n_pwm;
  logic [7:0] pwm_at_valid;

  // reference model state
  logic [15:0] model_word = '0;
  int          model_err  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.cmd_valid) begin
      n_valid++;
      pwm_at_valid = bus.pwm_wr;
    end
    if (bus.pwm_wr != 8'h00) n_pwm++;
    if (bus.clk_div_wr)      n_div++;
    if (bus.frame_err)       n_err++;
  endtask

  // Sends nbits sck edges carrying data[nbits-1:0] MSB first. coincide makes
  // the last sck rise and the cs_n rise change together. rst_at >= 0 pulses
  // reset just before that bit index (counted from the first bit).
  task automatic run_frame(input int nbits, input logic [31:0] data,
                           input bit coincide, input int rst_at);
    bit          was_reset;
    bit          accept;
    logic [3:0]  addr;
    logic [7:0]  exp_pwm;
    bit          exp_div;
    n_valid = 0; n_err = 0; n_div = 0; n_pwm = 0; pwm_at_valid = '0;
    was_reset = 0;
    bus.spi_cs_n = 1'b0;
    repeat (3) tick();
    for (int i = nbits - 1; i >= 0; i--) begin
      if (rst_at == nbits - 1 - i) begin
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_cmd_word", bus.cmd_word, 32'h0);
        check("reset_err_count", bus.err_count, 32'h0);
        rst_n = 1'b1;
        model_word = '0;
        model_err  = 0;
        was_reset  = 1;
      end
      bus.spi_mosi = data[i];
      repeat (4) tick();
      bus.spi_sck = 1'b1;
      if (coincide && i == 0) begin
        bus.spi_cs_n = 1'b1;
      end else begin
        repeat (4) tick();
        bus.spi_sck = 1'b0;
      end
    end
    if (!(coincide && nbits > 0)) begin
      repeat (2) tick();
      bus.spi_cs_n = 1'b1;
    end
    repeat (12) tick();
    bus.spi_sck = 1'b0;
    repeat (4) tick();

    accept  = !was_reset && (nbits == 16);
    addr    = data[15:12];
    exp_pwm = (accept && addr < 4'd8) ? (8'd1 << addr) : 8'd0;
    exp_div = accept && (addr == 4'd8);
    if (accept) model_word = data[15:0];
    if (!was_reset && !accept && model_err < 255) model_err++;

    check("cmd_valid_cycles", n_valid, accept ? 1 : 0);
    check("frame_err_cycles", n_err, (!was_reset && !accept) ? 1 : 0);
    check("pwm_wr_cycles", n_pwm, (exp_pwm != 0) ? 1 : 0);
    check("pwm_wr_value", pwm_at_valid, exp_pwm);
    check("clk_div_wr_cycles", n_div, exp_div ? 1 : 0);
    check("cmd_word", bus.cmd_word, model_word);
    check("err_count", bus.err_count, model_err);
  endtask

  initial begin
    bus.spi_cs_n = 1'b1;
    bus.spi_sck  = 1'b0;
    bus.spi_mosi = 1'b0;
    n_valid = 0; n_err = 0; n_div = 0; n_pwm = 0; pwm_at_valid = '0;
    repeat (4) tick();
    check("rst_cmd_word", bus.cmd_word, 32'h0);
    check("rst_cmd_valid", bus.cmd_valid, 32'h0);
    check("rst_pwm_wr", bus.pwm_wr, 32'h0);
    check("rst_clk_div_wr", bus.clk_div_wr, 32'h0);
    check("rst_frame_err", bus.frame_err, 32'h0);
    check("rst_err_count", bus.err_count, 32'h0);
    rst_n = 1'b1;
    repeat (6) tick();

    // directed frames
    run_frame(16, 32'h3155, 0, -1);
    run_frame(16, 32'h8005, 0, -1);
    run_frame(12, 32'h0ABC, 0, -1);
    run_frame(17, 32'h1_2345, 0, -1);
    run_frame(16, 32'h73FF, 0, -1);
    run_frame(16, 32'h1234, 0, 8);
    run_frame(16, 32'h0200, 0, -1);
    run_frame(16, 32'hF123, 0, -1);
    run_frame(0,  32'h0,    0, -1);
    run_frame(16, 32'h5A5A, 1, -1);
    run_frame(17, 32'h0_6A6A, 1, -1);
    run_frame(15, 32'h7FFF, 1, -1);

    // randomized frames, biased toward the valid length
    for (int k = 0; k < 40; k++) begin
      int          nb;
      logic [31:0] d;
      nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : 16;
      d  = $urandom;
      run_frame(nb, d, bit'($urandom_range(0, 1)), -1);
    end

    // drive the error counter into saturation
    for (int k = 0; k < 260; k++) begin
      run_frame(int'($urandom_range(0, 3)), $urandom, 0, -1);
    end
    check("err_count_saturated", bus.err_count, 32'd255);
    run_frame(16, 32'h2468, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
